// File: rtl/score_digits.sv
// score_digits: score keeper and glyph-ROM address feeder.
// Holds the left/right player scores, detects point edges, and maps the
// raster position onto glyph column/row/value for each score's box. The
// glyph ROM adds one registered cycle; pixel_en is delayed to match it.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   hpos, vpos              raster position (10 bits each)
//   point_left/right        level inputs, rising edge = point scored
//   clear                   synchronous score clear (new game)
//   digit_xpos/ypos/value   glyph column 0..2, row 0..4, digit 0..9 to ROM
//   pixel_en                ROM output of next cycle belongs to a digit box
//   score_left/right        live scores
//   game_over               set once either score reaches WIN_SCORE
module score_digits #(
  parameter int LEFT_X     = 256,
  parameter int RIGHT_X    = 352,
  parameter int TOP_Y      = 16,
  parameter int SCALE_LOG2 = 3,
  parameter int WIN_SCORE  = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       point_left,
  input  logic       point_right,
  input  logic       clear,
  output logic [1:0] digit_xpos,
  output logic [2:0] digit_ypos,
  output logic [3:0] digit_value,
  output logic       pixel_en,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over
);

  localparam int BOX_W = 3 << SCALE_LOG2;
  localparam int BOX_H = 5 << SCALE_LOG2;

  // Box bounds held one bit wider than the raster so the end limits cannot wrap.
  localparam logic [10:0] L_X0 = 11'(LEFT_X);
  localparam logic [10:0] L_X1 = 11'(LEFT_X + BOX_W);
  localparam logic [10:0] R_X0 = 11'(RIGHT_X);
  localparam logic [10:0] R_X1 = 11'(RIGHT_X + BOX_W);
  localparam logic [10:0] Y0   = 11'(TOP_Y);
  localparam logic [10:0] Y1   = 11'(TOP_Y + BOX_H);
  localparam logic [3:0]  WIN  = 4'(WIN_SCORE);

  logic       prev_l, prev_r;
  logic       ev_l, ev_r;
  logic [3:0] next_l, next_r;
  logic [3:0] shadow_l, shadow_r;
  logic       in_box_d1;

  logic [10:0] h_ext, v_ext;
  logic        in_y, in_l, in_r;
  logic [10:0] off_x, off_y;
  logic [3:0]  sel_value;

  // ---------------- score keeping ----------------
  assign ev_l = point_left  & ~prev_l;
  assign ev_r = point_right & ~prev_r;

  // Saturate at WIN_SCORE as a belt-and-braces guard; game_over normally
  // freezes the scores before they could go further.
  assign next_l = score_left  + {3'b000, ev_l && (score_left  != WIN)};
  assign next_r = score_right + {3'b000, ev_r && (score_right != WIN)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_l      <= 1'b0;
      prev_r      <= 1'b0;
      score_left  <= 4'd0;
      score_right <= 4'd0;
      game_over   <= 1'b0;
    end else begin
      prev_l <= point_left;
      prev_r <= point_right;
      if (clear) begin
        score_left  <= 4'd0;
        score_right <= 4'd0;
        game_over   <= 1'b0;
      end else if (!game_over) begin
        score_left  <= next_l;
        score_right <= next_r;
        game_over   <= (next_l == WIN) || (next_r == WIN);
      end
    end
  end

  // Displayed scores only change at frame start to avoid tearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_l <= 4'd0;
      shadow_r <= 4'd0;
    end else if (hpos == 10'd0 && vpos == 10'd0) begin
      shadow_l <= score_left;
      shadow_r <= score_right;
    end
  end

  // ---------------- box decode ----------------
  assign h_ext = {1'b0, hpos};
  assign v_ext = {1'b0, vpos};
  assign in_y  = (v_ext >= Y0) && (v_ext < Y1);
  assign in_l  = in_y && (h_ext >= L_X0) && (h_ext < L_X1);
  // Left box takes precedence if a configuration makes the boxes overlap.
  assign in_r  = in_y && !in_l && (h_ext >= R_X0) && (h_ext < R_X1);

  always_comb begin
    off_x     = 11'd0;
    off_y     = 11'd0;
    sel_value = 4'd0;
    if (in_l) begin
      off_x     = h_ext - L_X0;
      off_y     = v_ext - Y0;
      sel_value = shadow_l;
    end else if (in_r) begin
      off_x     = h_ext - R_X0;
      off_y     = v_ext - Y0;
      sel_value = shadow_r;
    end
  end

  // ---------------- pipeline ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_xpos  <= 2'd0;
      digit_ypos  <= 3'd0;
      digit_value <= 4'd0;
      in_box_d1   <= 1'b0;
      pixel_en    <= 1'b0;
    end else begin
      digit_xpos  <= 2'(off_x >> SCALE_LOG2);
      digit_ypos  <= 3'(off_y >> SCALE_LOG2);
      digit_value <= sel_value;
      in_box_d1   <= in_l | in_r;
      pixel_en    <= in_box_d1;
    end
  end

endmodule

// File: tb/tb_score_digits.sv
// tb_score_digits: randomized plus directed bench for score_digits, checked
// against a behavioural model of scores, frame-start shadowing and box geometry.
module tb_score_digits;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hpos, vpos;
  logic       point_left, point_right, clear;
  logic [1:0] digit_xpos;
  logic [2:0] digit_ypos;
  logic [3:0] digit_value;
  logic       pixel_en;
  logic [3:0] score_left, score_right;
  logic       game_over;

  score_digits dut (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos),
    .point_left(point_left), .point_right(point_right), .clear(clear),
    .digit_xpos(digit_xpos), .digit_ypos(digit_ypos), .digit_value(digit_value),
    .pixel_en(pixel_en), .score_left(score_left), .score_right(score_right),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_sl, m_sr, m_shl, m_shr;
  bit m_go, m_prev_l, m_prev_r;
  int m_x, m_y, m_val;
  bit m_in1, m_pe;

  function automatic void model_reset();
    m_sl = 0; m_sr = 0; m_shl = 0; m_shr = 0; m_go = 0;
    m_prev_l = 0; m_prev_r = 0;
    m_x = 0; m_y = 0; m_val = 0; m_in1 = 0; m_pe = 0;
  endfunction

  // Advances the model by one rising clock edge with the given inputs.
  function automatic void model_step(int h, int v, bit pl, bit pr, bit clr);
    bit el, er;
    m_pe = m_in1;
    if (v >= 16 && v < 56 && h >= 256 && h < 280) begin
      m_x = (h - 256) / 8; m_y = (v - 16) / 8; m_val = m_shl; m_in1 = 1;
    end else if (v >= 16 && v < 56 && h >= 352 && h < 376) begin
      m_x = (h - 352) / 8; m_y = (v - 16) / 8; m_val = m_shr; m_in1 = 1;
    end else begin
      m_x = 0; m_y = 0; m_val = 0; m_in1 = 0;
    end
    if (h == 0 && v == 0) begin
      m_shl = m_sl; m_shr = m_sr;
    end
    el = pl && !m_prev_l;
    er = pr && !m_prev_r;
    m_prev_l = pl; m_prev_r = pr;
    if (clr) begin
      m_sl = 0; m_sr = 0; m_go = 0;
    end else if (!m_go) begin
      if (el) m_sl++;
      if (er) m_sr++;
      m_go = (m_sl == 9) || (m_sr == 9);
    end
  endfunction

  task automatic compare_all();
    check("score_left",  int'(score_left),  m_sl);
    check("score_right", int'(score_right), m_sr);
    check("game_over",   int'(game_over),   int'(m_go));
    check("pixel_en",    int'(pixel_en),    int'(m_pe));
    check("digit_xpos",  int'(digit_xpos),  m_x);
    check("digit_ypos",  int'(digit_ypos),  m_y);
    check("digit_value", int'(digit_value), m_val);
  endtask

  // Called at a falling edge: apply inputs, step model, advance a cycle, check.
  task automatic cyc(input int h, input int v, input bit pl, input bit pr, input bit clr);
    hpos = 10'(h); vpos = 10'(v);
    point_left = pl; point_right = pr; clear = clr;
    model_step(h, v, pl, pr, clr);
    @(negedge clk);
    compare_all();
  endtask

  int pe_cnt;
  bit rl, rr;

  initial begin
    rst_n = 1'b0;
    hpos = '0; vpos = '0;
    point_left = 0; point_right = 0; clear = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // frame start then a sweep over the region containing both boxes
    cyc(0, 0, 0, 0, 0);
    pe_cnt = 0;
    for (int v = 0; v < 64; v++)
      for (int h = 240; h < 384; h++) begin
        cyc(h, v, 0, 0, 0);
        pe_cnt += int'(pixel_en);
      end
    for (int i = 0; i < 2; i++) begin
      cyc(500, 500, 0, 0, 0);
      pe_cnt += int'(pixel_en);
    end
    check("sweep_pe_count", pe_cnt, 2 * 24 * 40);

    // long-held point gives a single increment; display lags until frame start
    for (int i = 0; i < 10; i++) cyc(500, 500, 1, 0, 0);
    cyc(500, 500, 0, 0, 0);
    check("held_single_inc", int'(score_left), 1);
    cyc(263, 35, 0, 0, 0);
    check("box_x", int'(digit_xpos), 0);
    check("box_y", int'(digit_ypos), 2);
    check("shadow_old", int'(digit_value), 0);
    cyc(0, 0, 0, 0, 0);
    cyc(263, 35, 0, 0, 0);
    check("shadow_new", int'(digit_value), 1);
    cyc(280, 35, 0, 0, 0);
    cyc(500, 500, 0, 0, 0);
    check("right_edge_pe", int'(pixel_en), 0);

    // simultaneous edges
    cyc(500, 500, 1, 1, 0);
    check("both_left", int'(score_left), 2);
    check("both_right", int'(score_right), 1);

    // clear beats a same-cycle edge
    cyc(500, 500, 0, 0, 0);
    cyc(500, 500, 1, 0, 1);
    check("clear_l", int'(score_left), 0);
    check("clear_r", int'(score_right), 0);
    cyc(500, 500, 0, 0, 0);

    // right side to WIN_SCORE, then extra edges ignored
    for (int i = 0; i < 9; i++) begin
      cyc(500, 500, 0, 1, 0);
      cyc(500, 500, 0, 0, 0);
    end
    check("win_score", int'(score_right), 9);
    check("win_go", int'(game_over), 1);
    cyc(500, 500, 1, 1, 0);
    cyc(500, 500, 0, 0, 0);
    check("sat_right", int'(score_right), 9);
    check("frozen_left", int'(score_left), 0);
    cyc(500, 500, 0, 0, 1);

    // randomized play with frame starts scattered around
    rl = 0; rr = 0;
    for (int i = 0; i < 4000; i++) begin
      int h, v;
      if ($urandom_range(0, 49) == 0) begin
        h = 0; v = 0;
      end else begin
        h = $urandom_range(240, 390); v = $urandom_range(0, 70);
      end
      if ($urandom_range(0, 7) == 0) rl = !rl;
      if ($urandom_range(0, 7) == 0) rr = !rr;
      cyc(h, v, rl, rr, $urandom_range(0, 299) == 0);
    end

    // asynchronous reset mid-frame while inside a box
    cyc(500, 500, 0, 0, 1);
    cyc(500, 500, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(263, 35, 0, 0, 0);
    check("pre_reset_pe", int'(pixel_en), 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_pe", int'(pixel_en), 0);
    check("async_sl", int'(score_left), 0);
    check("async_sr", int'(score_right), 0);
    @(negedge clk);
    point_left = 0; point_right = 0; clear = 0;
    compare_all();
    rst_n = 1'b1;
    // point high at reset release counts as an edge
    cyc(500, 500, 1, 0, 0);
    check("edge_after_reset", int'(score_left), 1);
    cyc(500, 500, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
